// File: rtl/saci_master_serializer.sv
// SACI bus-side master: serialises a parallel register request onto saciCmd, then
// captures and checks the saciRsp frame and returns the result with a 4-phase ack.
module saci_master_serializer #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_CHIPS = 4,
  parameter int TIMEOUT   = 1024,
  localparam int CHIP_W   = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
  input  logic                 CLK,
  input  logic                 rstL,
  input  logic                 req,
  input  logic [CHIP_W-1:0]    chip,
  input  logic                 op,
  input  logic [6:0]           cmd,
  input  logic [11:0]          addr,
  input  logic [31:0]          wrData,
  output logic                 ack,
  output logic                 fail,
  output logic [31:0]          rdData,
  output logic                 saciClk,
  output logic [NUM_CHIPS-1:0] saciSelL,
  output logic                 saciCmd,
  input  logic                 saciRsp
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SHIFT_OUT, WAIT_RSP, SHIFT_IN, DONE} stateT;

  stateT                state;
  stateT                nextState;
  logic [DIV_W-1:0]     divCnt;
  logic                 tick;
  logic                 fallTick;
  logic                 riseTick;
  logic [51:0]          cmdShift;
  logic [5:0]           bitsLeft;
  logic [50:0]          rspShift;
  logic [5:0]           rspCnt;
  logic [TO_W-1:0]      timeoutCnt;
  logic                 timeoutHit;
  logic                 opLat;
  logic [6:0]           cmdLat;
  logic [11:0]          addrLat;
  logic [CHIP_W-1:0]    chipLat;
  logic [CHIP_W-1:0]    selChip;
  logic [51:0]          rspWord;
  logic [NUM_CHIPS-1:0] selNext;
  logic                 ackNext;

  assign tick       = (divCnt == DIV_W'(CLK_DIV - 1));
  assign fallTick   = tick & saciClk;
  assign riseTick   = tick & ~saciClk;
  assign rspWord    = {rspShift, saciRsp};
  assign timeoutHit = (timeoutCnt == TO_W'(TIMEOUT - 1));

  // saciClk runs continuously, independent of any transaction
  always_ff @(posedge CLK or negedge rstL) begin
    if (!rstL) begin
      divCnt  <= '0;
      saciClk <= 1'b0;
    end else if (tick) begin
      divCnt  <= '0;
      saciClk <= ~saciClk;
    end else begin
      divCnt  <= divCnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rstL) begin
    if (!rstL) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (fallTick && req && !ack) nextState = SHIFT_OUT;
      SHIFT_OUT: if (fallTick && bitsLeft == 6'd0) nextState = WAIT_RSP;
      WAIT_RSP: begin
        if (riseTick) begin
          if (saciRsp)         nextState = SHIFT_IN;
          else if (timeoutHit) nextState = DONE;
        end
      end
      SHIFT_IN:  if (riseTick && rspCnt == 6'd1) nextState = DONE;
      DONE:      if (!req) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Selects and ack are decoded from the next state and registered, so they are glitch-free
  always_comb begin
    selChip = (state == IDLE) ? chip : chipLat;
    selNext = '1;
    ackNext = (nextState == DONE);
    if (nextState inside {SHIFT_OUT, WAIT_RSP, SHIFT_IN}) begin
      for (int i = 0; i < NUM_CHIPS; i++) begin
        if (selChip == CHIP_W'(i)) selNext[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge rstL) begin
    if (!rstL) begin
      saciSelL   <= '1;
      saciCmd    <= 1'b0;
      ack        <= 1'b0;
      fail       <= 1'b0;
      rdData     <= '0;
      cmdShift   <= '0;
      bitsLeft   <= '0;
      rspShift   <= '0;
      rspCnt     <= '0;
      timeoutCnt <= '0;
      opLat      <= 1'b0;
      cmdLat     <= '0;
      addrLat    <= '0;
      chipLat    <= '0;
    end else begin
      saciSelL <= selNext;
      ack      <= ackNext;
      case (state)
        IDLE: begin
          if (fallTick && req && !ack) begin
            opLat    <= op;
            cmdLat   <= cmd;
            addrLat  <= addr;
            chipLat  <= chip;
            cmdShift <= {op, cmd, addr, wrData};
            bitsLeft <= op ? 6'd52 : 6'd20;
            saciCmd  <= 1'b1;
          end
        end
        SHIFT_OUT: begin
          if (fallTick) begin
            if (bitsLeft != 6'd0) begin
              saciCmd  <= cmdShift[51];
              cmdShift <= {cmdShift[50:0], 1'b0};
              bitsLeft <= bitsLeft - 1'b1;
            end else begin
              saciCmd    <= 1'b0;
              timeoutCnt <= '0;
            end
          end
        end
        WAIT_RSP: begin
          if (riseTick) begin
            if (saciRsp) begin
              rspCnt <= 6'd52;
            end else begin
              timeoutCnt <= timeoutCnt + 1'b1;
              if (timeoutHit) fail <= 1'b1;
            end
          end
        end
        SHIFT_IN: begin
          if (riseTick) begin
            rspShift <= rspWord[50:0];
            rspCnt   <= rspCnt - 1'b1;
            if (rspCnt == 6'd1) begin
              rdData <= rspWord[31:0];
              fail   <= (rspWord[51:32] != {opLat, cmdLat, addrLat});
            end
          end
        end
        DONE: begin
          if (!req) fail <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_saci_master_serializer.sv
// Scoreboard bench for saci_master_serializer: a behavioural SACI slave checks command
// frames, and an ack monitor checks rdData/fail against queued expectations.
module tb_saci_master_serializer;

  localparam int CLK_DIV   = 4;
  localparam int NUM_CHIPS = 4;
  localparam int TIMEOUT   = 1024;
  localparam logic [1:0] MODE_NORMAL  = 2'd0;
  localparam logic [1:0] MODE_SILENT  = 2'd1;
  localparam logic [1:0] MODE_CORRUPT = 2'd2;

  logic        CLK = 1'b0;
  logic        rstL = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  chip = '0;
  logic        op = 1'b0;
  logic [6:0]  cmd = '0;
  logic [11:0] addr = '0;
  logic [31:0] wrData = '0;
  logic        ack;
  logic        fail;
  logic [31:0] rdData;
  logic        saciClk;
  logic [3:0]  saciSelL;
  logic        saciCmd;
  logic        saciRsp;

  typedef struct {
    logic [52:0] bits;
    int          len;
    logic [3:0]  selL;
  } frameExpT;

  typedef struct {
    logic        fail;
    logic [31:0] rdData;
  } rspExpT;

  frameExpT    expFrameQ[$];
  rspExpT      expRspQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  slaveMode = MODE_NORMAL;
  int          slaveDelay = 0;
  logic [31:0] slaveReadData = '0;
  int          slaveBitCnt = 0;
  int          selChanges = 0;

  saci_master_serializer #(
    .CLK_DIV(CLK_DIV), .NUM_CHIPS(NUM_CHIPS), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .rstL(rstL), .req(req), .chip(chip), .op(op), .cmd(cmd),
    .addr(addr), .wrData(wrData), .ack(ack), .fail(fail), .rdData(rdData),
    .saciClk(saciClk), .saciSelL(saciSelL), .saciCmd(saciCmd), .saciRsp(saciRsp)
  );

  always #5 CLK = ~CLK;

  always @(saciSelL) selChanges = selChanges + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Behavioural ASIC slave: samples saciCmd on saciClk rise, drives saciRsp on fall
  initial begin : slaveModel
    logic [52:0] fr;
    logic [52:0] rsp;
    logic [19:0] hdr;
    logic [31:0] data;
    logic [3:0]  selSeen;
    logic        selStable;
    logic        aborted;
    int          n;
    int          len;
    frameExpT    e;
    saciRsp = 1'b0;
    forever begin
      @(posedge saciClk);
      if (saciSelL != 4'hF && saciCmd === 1'b1) begin
        fr = 53'd1; n = 1; len = 53; selSeen = saciSelL; selStable = 1'b1; aborted = 1'b0;
        slaveBitCnt = 1;
        while (n < len && !aborted) begin
          @(posedge saciClk);
          if (saciSelL == 4'hF) begin
            aborted = 1'b1;
          end else begin
            if (saciSelL != selSeen) selStable = 1'b0;
            fr = {fr[51:0], saciCmd};
            n++;
            slaveBitCnt = n;
            if (n == 2) len = saciCmd ? 53 : 21;
          end
        end
        slaveBitCnt = 0;
        if (!aborted) begin
          if (expFrameQ.size() == 0) begin
            checkOutput("unexpectedFrame", 64'd1, 64'd0);
          end else begin
            e = expFrameQ.pop_front();
            checkOutput("cmdFrame", 64'(fr), 64'(e.bits));
            checkOutput("frameLen", 64'(n), 64'(e.len));
            checkOutput("frameSelL", 64'(selSeen), 64'(e.selL));
            checkOutput("selStable", 64'(selStable), 64'd1);
          end
          hdr  = (n == 21) ? fr[19:0] : fr[51:32];
          data = (n == 21) ? slaveReadData : fr[31:0];
          if (slaveMode == MODE_CORRUPT) hdr = hdr ^ 20'h1;
          rsp = {1'b1, hdr, data};
          if (slaveMode == MODE_SILENT) begin
            repeat (TIMEOUT - 1) @(posedge saciClk);
            #1 checkOutput("ackBeforeTimeout", 64'(ack), 64'd0);
            @(posedge saciClk);
            #1;
            checkOutput("timeoutAck", 64'(ack), 64'd1);
            checkOutput("timeoutFail", 64'(fail), 64'd1);
            checkOutput("timeoutSelL", 64'(saciSelL), 64'hF);
          end else begin
            repeat (slaveDelay) @(negedge saciClk);
            for (int i = 52; i >= 0; i--) begin
              @(negedge saciClk);
              saciRsp = rsp[i];
            end
            @(negedge saciClk);
            saciRsp = 1'b0;
          end
        end
      end
    end
  end

  initial begin : ackMonitor
    logic   ackPrev;
    rspExpT e;
    ackPrev = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack === 1'b1 && ackPrev !== 1'b1) begin
        if (expRspQ.size() == 0) begin
          checkOutput("unexpectedAck", 64'd1, 64'd0);
        end else begin
          e = expRspQ.pop_front();
          checkOutput("rspFail", 64'(fail), 64'(e.fail));
          checkOutput("rdData", 64'(rdData), 64'(e.rdData));
        end
      end
      ackPrev = ack;
    end
  end

  task automatic applyStimulus(input logic [1:0] c, input logic o, input logic [6:0] cm,
                               input logic [11:0] a, input logic [31:0] d,
                               input logic [52:0] expBits, input int expLen,
                               input logic [3:0] expSelL, input logic expFail,
                               input logic [31:0] expRd, output int startCycles);
    frameExpT fe;
    rspExpT   re;
    int       cyc;
    fe.bits = expBits; fe.len = expLen; fe.selL = expSelL;
    expFrameQ.push_back(fe);
    re.fail = expFail; re.rdData = expRd;
    expRspQ.push_back(re);
    @(negedge CLK);
    chip = c; op = o; cmd = cm; addr = a; wrData = d; req = 1'b1;
    cyc = 0;
    startCycles = -1;
    while (ack !== 1'b1 && cyc < 20000) begin
      @(negedge CLK);
      cyc++;
      if (startCycles < 0 && saciSelL != 4'hF) startCycles = cyc;
    end
    if (ack !== 1'b1) checkOutput("ackWait", 64'(ack), 64'd1);
    req = 1'b0;
    @(negedge CLK);
    checkOutput("ackRelease", 64'(ack), 64'd0);
    checkOutput("failRelease", 64'(fail), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "SaciClk"}, 64'(saciClk), 64'd0);
    checkOutput({tag, "SaciSelL"}, 64'(saciSelL), 64'hF);
    checkOutput({tag, "SaciCmd"}, 64'(saciCmd), 64'd0);
    checkOutput({tag, "Ack"}, 64'(ack), 64'd0);
    checkOutput({tag, "Fail"}, 64'(fail), 64'd0);
    checkOutput({tag, "RdData"}, 64'(rdData), 64'd0);
  endtask

  initial begin : mainSeq
    int lat1;
    int lat2;
    int cyc;
    int selBase;
    $display("[TB] start");
    #2 rstL = 1'b0;
    #1 checkResetValues("reset");
    repeat (3) @(negedge CLK);
    rstL = 1'b1;

    // write with echo, then read with a delayed response
    slaveMode = MODE_NORMAL; slaveDelay = 0;
    applyStimulus(2'd1, 1'b1, 7'h05, 12'h0A3, 32'hDEADBEEF, 53'h1850A3_DEADBEEF, 53,
                  4'b1101, 1'b0, 32'hDEADBEEF, lat1);
    slaveDelay = 3; slaveReadData = 32'h12345678;
    applyStimulus(2'd0, 1'b0, 7'h02, 12'h010, 32'h0, 53'h102010, 21,
                  4'b1110, 1'b0, 32'h12345678, lat1);

    // silent slave: timeout, rdData keeps the previous value
    slaveMode = MODE_SILENT;
    applyStimulus(2'd2, 1'b0, 7'h02, 12'h010, 32'hFFFFFFFF, 53'h102010, 21,
                  4'b1011, 1'b1, 32'h12345678, lat1);

    // echoed address differs from the request
    slaveMode = MODE_CORRUPT; slaveDelay = 1; slaveReadData = 32'hCAFEF00D;
    applyStimulus(2'd0, 1'b0, 7'h02, 12'h010, 32'h0, 53'h102010, 21,
                  4'b1110, 1'b1, 32'hCAFEF00D, lat1);

    // reset pulse while bit 30 of a write is on the wire
    slaveMode = MODE_NORMAL; slaveDelay = 0;
    @(negedge CLK);
    chip = 2'd1; op = 1'b1; cmd = 7'h05; addr = 12'h0A3; wrData = 32'hDEADBEEF; req = 1'b1;
    cyc = 0;
    while (slaveBitCnt < 30 && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput("reachedBit30", 64'(slaveBitCnt == 30), 64'd1);
    rstL = 1'b0;
    #1 checkResetValues("midReset");
    req = 1'b0;
    @(negedge CLK);
    rstL = 1'b1;
    applyStimulus(2'd3, 1'b1, 7'h7F, 12'hFFF, 32'h00000001, 53'h1FFFFF_00000001, 53,
                  4'b0111, 1'b0, 32'h00000001, lat1);

    // back-to-back requests
    slaveReadData = 32'hA5A5A5A5;
    selBase = selChanges;
    applyStimulus(2'd1, 1'b0, 7'h02, 12'h010, 32'h0, 53'h102010, 21,
                  4'b1101, 1'b0, 32'hA5A5A5A5, lat1);
    applyStimulus(2'd2, 1'b1, 7'h05, 12'h0A3, 32'h0, 53'h1850A3_00000000, 53,
                  4'b1011, 1'b0, 32'h00000000, lat2);
    checkOutput("b2bStartLatency", 64'(lat2 >= 1 && lat2 <= 2 * CLK_DIV), 64'd1);
    checkOutput("selLTransitions", 64'(selChanges - selBase), 64'd4);

    repeat (20) @(negedge CLK);
    checkOutput("frameQueueEmpty", 64'(expFrameQ.size()), 64'd0);
    checkOutput("rspQueueEmpty", 64'(expRspQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
